// File: rtl/overlay_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// overlay_mac_sequencer_if
// Connection bundle between the MAC job sequencer and one overlay instance.
//   ov_mode, ov_a_sign, ov_b_sign : overlay configuration, held for a whole job
//   ov_a, ov_b                    : operand pair presented to the multiplier
//   ov_result_2                   : ALU X input (bias on the first product, S_reg after)
//   ov_cin                        : ALU carry-in, tied low
//   ov_s_reg, ov_carry_reg        : accumulator and lane carries returned by the overlay
// master = sequencer side, slave = overlay side.
// ---------------------------------------------------------------------------
interface overlay_mac_sequencer_if;
    logic        ov_mode;
    logic        ov_a_sign;
    logic        ov_b_sign;
    logic [31:0] ov_a;
    logic [31:0] ov_b;
    logic [31:0] ov_result_2;
    logic        ov_cin;
    logic [31:0] ov_s_reg;
    logic [1:0]  ov_carry_reg;

    modport master (
        output ov_mode, ov_a_sign, ov_b_sign, ov_a, ov_b, ov_result_2, ov_cin,
        input  ov_s_reg, ov_carry_reg
    );

    modport slave (
        input  ov_mode, ov_a_sign, ov_b_sign, ov_a, ov_b, ov_result_2, ov_cin,
        output ov_s_reg, ov_carry_reg
    );
endinterface

// File: rtl/overlay_mac_sequencer.sv
// ---------------------------------------------------------------------------
// overlay_mac_sequencer
// Job controller for the 2x2-chunk 16x16 overlay MAC. Streams (a,b) pairs into
// the overlay one per cycle and produces one dot-product per job by steering
// S_reg back onto the ALU X input, with the job bias substituted for the first
// product.
// Ports:
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   start, cfg_*          : job request and configuration (sampled in IDLE only)
//   abort                 : synchronous job cancel
//   in_valid/in_ready     : operand pair handshake, in_a/in_b operands
//   ov                    : overlay connection (master side)
//   busy                  : a job is in progress
//   res_valid/data/carry  : one-cycle result pulse, data/carry held afterwards
// ---------------------------------------------------------------------------
module overlay_mac_sequencer #(
    parameter int LEN_W   = 16,
    parameter int ALU_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_mode,
    input  logic                 cfg_a_sign,
    input  logic                 cfg_b_sign,
    input  logic [31:0]          cfg_bias,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 in_ready,
    overlay_mac_sequencer_if.master ov,
    output logic                 busy,
    output logic                 res_valid,
    output logic [31:0]          res_data,
    output logic [1:0]           res_carry
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Tag travelling alongside each issued pair until it reaches the ALU.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    state_t           state_r, state_next_s;
    logic [LEN_W-1:0] remaining_r, remaining_next_s;
    logic             first_pend_r, first_pend_next_s;
    tag_t             tag_r [0:ALU_LAT];
    tag_t             alu_tag_s;
    tag_t             issue_tag_s;
    logic             retire_r;
    logic [31:0]      issue_a_s, issue_b_s;
    logic             load_cfg_s, clear_s, res_fire_s;
    logic [31:0]      ov_a_r, ov_b_r, bias_r;
    logic             mode_r, a_sign_r, b_sign_r;
    logic             res_valid_r;
    logic [31:0]      res_data_r;
    logic [1:0]       res_carry_r;

    assign alu_tag_s = tag_r[ALU_LAT];

    // Next-state, issue and bookkeeping decisions for the job FSM.
    always_comb begin
        state_next_s      = state_r;
        remaining_next_s  = remaining_r;
        first_pend_next_s = first_pend_r;
        issue_a_s         = 32'd0;
        issue_b_s         = 32'd0;
        issue_tag_s       = '0;
        load_cfg_s        = 1'b0;
        clear_s           = 1'b0;
        res_fire_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    load_cfg_s = 1'b1;
                    if (cfg_len == {LEN_W{1'b0}}) begin
                        // Empty job: one internal zero pair carries the bias through.
                        issue_tag_s      = '{vld: 1'b1, first: 1'b1, last: 1'b1};
                        remaining_next_s = {LEN_W{1'b0}};
                        state_next_s     = ST_DRAIN;
                    end else begin
                        remaining_next_s  = cfg_len;
                        first_pend_next_s = 1'b1;
                        state_next_s      = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (in_valid) begin
                    issue_a_s         = in_a;
                    issue_b_s         = in_b;
                    issue_tag_s       = '{vld: 1'b1, first: first_pend_r,
                                          last: (remaining_r == LEN_W'(1))};
                    first_pend_next_s = 1'b0;
                    remaining_next_s  = remaining_r - LEN_W'(1);
                    if (remaining_r == LEN_W'(1)) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (retire_r) begin
                    res_fire_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and job counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            remaining_r  <= {LEN_W{1'b0}};
            first_pend_r <= 1'b0;
        end else if (clear_s) begin
            state_r      <= state_next_s;
            remaining_r  <= {LEN_W{1'b0}};
            first_pend_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            remaining_r  <= remaining_next_s;
            first_pend_r <= first_pend_next_s;
        end
    end

    // Operand registers and tag pipeline; bubbles and cancels push zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_a_r   <= 32'd0;
            ov_b_r   <= 32'd0;
            retire_r <= 1'b0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else if (clear_s) begin
            ov_a_r   <= 32'd0;
            ov_b_r   <= 32'd0;
            retire_r <= 1'b0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            ov_a_r   <= issue_a_s;
            ov_b_r   <= issue_b_s;
            tag_r[0] <= issue_tag_s;
            for (int i = 1; i <= ALU_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            // Last product is leaving the ALU; S_reg is final one edge later.
            retire_r <= alu_tag_s.vld & alu_tag_s.last;
        end
    end

    // Job configuration, captured only when a job is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r   <= 1'b0;
            a_sign_r <= 1'b0;
            b_sign_r <= 1'b0;
            bias_r   <= 32'd0;
        end else if (load_cfg_s) begin
            mode_r   <= cfg_mode;
            a_sign_r <= cfg_a_sign;
            b_sign_r <= cfg_b_sign;
            bias_r   <= cfg_bias;
        end
    end

    // Result capture; data and carry hold until the next completed job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 32'd0;
            res_carry_r <= 2'd0;
        end else begin
            res_valid_r <= res_fire_s;
            if (res_fire_s) begin
                res_data_r  <= ov.ov_s_reg;
                res_carry_r <= ov.ov_carry_reg;
            end
        end
    end

    assign ov.ov_a      = ov_a_r;
    assign ov.ov_b      = ov_b_r;
    assign ov.ov_mode   = mode_r;
    assign ov.ov_a_sign = a_sign_r;
    assign ov.ov_b_sign = b_sign_r;
    assign ov.ov_cin    = 1'b0;
    // First product of the job adds onto the bias, every later one onto S_reg.
    assign ov.ov_result_2 = (alu_tag_s.vld && alu_tag_s.first) ? bias_r : ov.ov_s_reg;

    assign in_ready  = (state_r == ST_RUN);
    assign busy      = (state_r != ST_IDLE);
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_carry = res_carry_r;

endmodule
